// File: rtl/eth_irq_coalesce_pkg.sv
// Shared definitions for the Ethernet interrupt coalescing block: register map,
// channel indices, register bus types and small helpers.
package eth_irq_coalesce_pkg;

  localparam logic [31:0] IRQ_EN_OFFS    = 32'h00;
  localparam logic [31:0] PENDING_OFFS   = 32'h04;
  localparam logic [31:0] RX_THRESH_OFFS = 32'h08;
  localparam logic [31:0] TX_THRESH_OFFS = 32'h0C;
  localparam logic [31:0] TIMEOUT_OFFS   = 32'h10;
  localparam logic [31:0] RX_CNT_OFFS    = 32'h14;
  localparam logic [31:0] TX_CNT_OFFS    = 32'h18;

  localparam int CH_RX  = 0;
  localparam int CH_TX  = 1;
  localparam int NUM_CH = 2;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_s;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_s;

  typedef enum logic [2:0] {
    REG_IRQ_EN,
    REG_PENDING,
    REG_RX_THRESH,
    REG_TX_THRESH,
    REG_TIMEOUT,
    REG_RX_CNT,
    REG_TX_CNT,
    REG_NONE
  } reg_sel_e;

  typedef enum logic {
    CH_IDLE,
    CH_ARMED
  } chan_state_e;

  // Replace only the bytes enabled by wstrb; the rest keep their current value.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/eth_irq_coalesce_chan.sv
// One coalescing channel: rising-edge detect, saturating event counter and idle
// timer; pulses fire_o for one cycle when the threshold or timeout is reached.
module eth_irq_coalesce_chan
  import eth_irq_coalesce_pkg::*;
#(
  parameter int unsigned CntWidth   = 16,
  parameter int unsigned TimerWidth = 24
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  irq_i,
  input  logic [CntWidth-1:0]   thresh,
  input  logic [TimerWidth-1:0] timeout,
  output logic                  fire_o,
  output logic [CntWidth-1:0]   cnt_o
);

  chan_state_e           state_reg, state_next;
  logic [CntWidth-1:0]   cnt_reg, cnt_next;
  logic [TimerWidth-1:0] timer_reg, timer_next;
  logic                  irq_q_reg;

  logic                  event_w;
  logic [CntWidth-1:0]   thr_eff;
  logic [CntWidth-1:0]   cnt_inc;
  logic [TimerWidth-1:0] timer_inc;
  logic                  fire;

  assign event_w   = irq_i & ~irq_q_reg;
  assign thr_eff   = (thresh == '0) ? CntWidth'(1) : thresh;
  assign cnt_inc   = (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;
  // Saturation only matters with the timeout path disabled; otherwise the
  // timer fires and clears long before reaching all-ones.
  assign timer_inc = (timer_reg == '1) ? timer_reg : timer_reg + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= CH_IDLE;
      cnt_reg   <= '0;
      timer_reg <= '0;
      irq_q_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      timer_reg <= timer_next;
      irq_q_reg <= irq_i;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    timer_next = timer_reg;
    fire       = 1'b0;

    case (state_reg)
      CH_IDLE: begin
        if (event_w) begin
          cnt_next   = CntWidth'(1);
          timer_next = '0;
          state_next = CH_ARMED;
          fire       = (cnt_next >= thr_eff);
        end
      end
      CH_ARMED: begin
        if (event_w) cnt_next = cnt_inc;
        // timer_next equals the number of cycles since the arming event.
        timer_next = timer_inc;
        fire = (cnt_next >= thr_eff) ||
               ((timeout != '0) && (timer_next == timeout));
      end
      default: state_next = CH_IDLE;
    endcase

    if (fire) begin
      state_next = CH_IDLE;
      cnt_next   = '0;
      timer_next = '0;
    end
  end

  assign fire_o = fire;
  assign cnt_o  = cnt_reg;

endmodule

// File: rtl/eth_irq_coalesce.sv
// Interrupt moderation for the Ethernet RX/TX interrupt levels: register file,
// PENDING with write-1-to-clear, address decode and the masked irq_o flop.
module eth_irq_coalesce
  import eth_irq_coalesce_pkg::*;
#(
  parameter int unsigned CntWidth   = 16,
  parameter int unsigned TimerWidth = 24,
  parameter type reg_req_t = eth_irq_coalesce_pkg::reg_req_s,
  parameter type reg_rsp_t = eth_irq_coalesce_pkg::reg_rsp_s
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  reg_req_t reg_req_i,
  output reg_rsp_t reg_rsp_o,
  input  logic     eth_rx_irq_i,
  input  logic     eth_tx_irq_i,
  output logic     irq_o
);

  logic [1:0]            irq_en_reg, irq_en_next;
  logic [1:0]            pending_reg, pending_next;
  logic [CntWidth-1:0]   thresh_reg [NUM_CH];
  logic [CntWidth-1:0]   thresh_next [NUM_CH];
  logic [TimerWidth-1:0] timeout_reg, timeout_next;
  logic                  irq_reg, irq_next;

  logic [NUM_CH-1:0]     ch_irq;
  logic [NUM_CH-1:0]     fire;
  logic [CntWidth-1:0]   cnt_arr [NUM_CH];

  reg_sel_e              reg_sel;
  logic                  bus_err;
  logic                  wr_en;
  logic [31:0]           rd_val;
  logic [31:0]           wr_merged;
  logic [1:0]            pend_clr;

  assign ch_irq[CH_RX] = eth_rx_irq_i;
  assign ch_irq[CH_TX] = eth_tx_irq_i;

  always_comb begin
    case (reg_req_i.addr)
      IRQ_EN_OFFS:    reg_sel = REG_IRQ_EN;
      PENDING_OFFS:   reg_sel = REG_PENDING;
      RX_THRESH_OFFS: reg_sel = REG_RX_THRESH;
      TX_THRESH_OFFS: reg_sel = REG_TX_THRESH;
      TIMEOUT_OFFS:   reg_sel = REG_TIMEOUT;
      RX_CNT_OFFS:    reg_sel = REG_RX_CNT;
      TX_CNT_OFFS:    reg_sel = REG_TX_CNT;
      default:        reg_sel = REG_NONE;
    endcase
  end

  always_comb begin
    case (reg_sel)
      REG_IRQ_EN:    rd_val = 32'(irq_en_reg);
      REG_PENDING:   rd_val = 32'(pending_reg);
      REG_RX_THRESH: rd_val = 32'(thresh_reg[CH_RX]);
      REG_TX_THRESH: rd_val = 32'(thresh_reg[CH_TX]);
      REG_TIMEOUT:   rd_val = 32'(timeout_reg);
      REG_RX_CNT:    rd_val = 32'(cnt_arr[CH_RX]);
      REG_TX_CNT:    rd_val = 32'(cnt_arr[CH_TX]);
      default:       rd_val = '0;
    endcase
  end

  assign bus_err   = reg_req_i.valid &&
                     ((reg_sel == REG_NONE) ||
                      (reg_req_i.write && ((reg_sel == REG_RX_CNT) || (reg_sel == REG_TX_CNT))));
  assign wr_en     = reg_req_i.valid && reg_req_i.write && !bus_err;
  // Merging into the read view keeps unused bits at zero after the slice below.
  assign wr_merged = apply_wstrb(rd_val, reg_req_i.wdata, reg_req_i.wstrb);

  always_comb begin
    reg_rsp_o       = '0;
    reg_rsp_o.ready = reg_req_i.valid;
    reg_rsp_o.error = bus_err;
    reg_rsp_o.rdata = bus_err ? 32'h0 : rd_val;
  end

  always_comb begin
    pend_clr = '0;
    if (wr_en && (reg_sel == REG_PENDING) && reg_req_i.wstrb[0]) begin
      pend_clr = reg_req_i.wdata[1:0];
    end
    // A fire in the same cycle as the clear wins.
    pending_next = (pending_reg & ~pend_clr) | fire;
    irq_en_next  = (wr_en && (reg_sel == REG_IRQ_EN)) ? wr_merged[1:0] : irq_en_reg;
    timeout_next = (wr_en && (reg_sel == REG_TIMEOUT)) ? wr_merged[TimerWidth-1:0] : timeout_reg;
    irq_next     = |(pending_next & irq_en_next);
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    localparam reg_sel_e ThrSel = (gi == CH_RX) ? REG_RX_THRESH : REG_TX_THRESH;

    assign thresh_next[gi] = (wr_en && (reg_sel == ThrSel)) ?
                             wr_merged[CntWidth-1:0] : thresh_reg[gi];

    eth_irq_coalesce_chan #(
      .CntWidth   (CntWidth),
      .TimerWidth (TimerWidth)
    ) u_chan (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .irq_i   (ch_irq[gi]),
      .thresh  (thresh_reg[gi]),
      .timeout (timeout_reg),
      .fire_o  (fire[gi]),
      .cnt_o   (cnt_arr[gi])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_en_reg  <= '0;
      pending_reg <= '0;
      timeout_reg <= '0;
      irq_reg     <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) thresh_reg[i] <= CntWidth'(1);
    end else begin
      irq_en_reg  <= irq_en_next;
      pending_reg <= pending_next;
      timeout_reg <= timeout_next;
      irq_reg     <= irq_next;
      for (int i = 0; i < NUM_CH; i++) thresh_reg[i] <= thresh_next[i];
    end
  end

  assign irq_o = irq_reg;

endmodule

// File: tb/tb_eth_irq_coalesce.sv
// Self-checking bench for eth_irq_coalesce: directed scenarios followed by
// randomized traffic, all checked against a cycle-level behavioural model.
module tb_eth_irq_coalesce;
  import eth_irq_coalesce_pkg::*;

  localparam int CW = 16;
  localparam int TW = 24;

  logic     clk = 1'b0;
  logic     rst_n = 1'b0;
  reg_req_s req;
  reg_rsp_s rsp;
  logic     rx, tx;
  logic     irq;

  always #5 clk = ~clk;

  eth_irq_coalesce #(
    .CntWidth   (CW),
    .TimerWidth (TW),
    .reg_req_t  (reg_req_s),
    .reg_rsp_t  (reg_rsp_s)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .reg_req_i    (req),
    .reg_rsp_o    (rsp),
    .eth_rx_irq_i (rx),
    .eth_tx_irq_i (tx),
    .irq_o        (irq)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Behavioural model: counts events since arming and the arming cycle number.
  int unsigned m_en, m_pend, m_to;
  int unsigned m_thr [2];
  int unsigned m_cnt [2];
  int          m_arm_cyc [2];
  bit          m_armed [2];
  bit          m_prev [2];
  bit          m_irq;

  logic [31:0] last_rdata;
  logic        last_err;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    case (a)
      32'h00:  return m_en;
      32'h04:  return m_pend;
      32'h08:  return m_thr[0];
      32'h0C:  return m_thr[1];
      32'h10:  return m_to;
      32'h14:  return m_cnt[0];
      32'h18:  return m_cnt[1];
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_en = 0; m_pend = 0; m_to = 0; m_irq = 0;
    for (int c = 0; c < 2; c++) begin
      m_thr[c] = 1; m_cnt[c] = 0; m_armed[c] = 0; m_prev[c] = 0; m_arm_cyc[c] = 0;
    end
  endtask

  // One clock cycle: drive inputs and an optional bus access, check the bus
  // response, advance the model, then check irq_o after the edge.
  task automatic tick(input bit r, input bit t, input bit v, input bit w,
                      input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit          exp_err, known;
    bit          lvl [2];
    bit          fired [2];
    logic [31:0] merged;
    int unsigned thr_eff, clr;
    rx = r; tx = t;
    req.valid = v; req.write = w; req.addr = a; req.wdata = d; req.wstrb = s;
    #1;
    known   = a inside {32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18};
    exp_err = !known || (w && (a inside {32'h14, 32'h18}));
    last_rdata = rsp.rdata;
    last_err   = rsp.error;
    if (v) begin
      check_eq("ready", {31'b0, rsp.ready}, 32'h1);
      check_eq(w ? "wr_err" : "rd_err", {31'b0, rsp.error}, {31'b0, exp_err});
      if (!w && !exp_err) check_eq("rdata", rsp.rdata, model_read(a));
      $display("[TB] cyc=%0d %s addr=0x%02h wdata=0x%0h wstrb=%h rdata=0x%0h err=%0b",
               cyc, w ? "WR" : "RD", a, d, s, rsp.rdata, rsp.error);
    end

    lvl[0] = r; lvl[1] = t;
    for (int c = 0; c < 2; c++) begin
      fired[c] = 0;
      thr_eff  = (m_thr[c] == 0) ? 1 : m_thr[c];
      if (!m_armed[c]) begin
        if (lvl[c] && !m_prev[c]) begin
          if (thr_eff <= 1) fired[c] = 1;
          else begin
            m_armed[c] = 1; m_cnt[c] = 1; m_arm_cyc[c] = cyc;
          end
        end
      end else begin
        if (lvl[c] && !m_prev[c] && m_cnt[c] < 32'hFFFF) m_cnt[c]++;
        if (m_cnt[c] >= thr_eff || (m_to != 0 && (cyc - m_arm_cyc[c]) == int'(m_to)))
          fired[c] = 1;
      end
      if (fired[c]) begin
        m_armed[c] = 0; m_cnt[c] = 0;
      end
      m_prev[c] = lvl[c];
    end

    clr = (v && w && !exp_err && a == 32'h04 && s[0]) ? d[1:0] : 0;
    m_pend = (m_pend & ~clr & 3) | (fired[0] ? 1 : 0) | (fired[1] ? 2 : 0);
    if (v && w && !exp_err) begin
      merged = model_read(a);
      for (int b = 0; b < 4; b++) if (s[b]) merged[8*b +: 8] = d[8*b +: 8];
      case (a)
        32'h00: m_en     = merged & 32'h3;
        32'h08: m_thr[0] = merged & 32'hFFFF;
        32'h0C: m_thr[1] = merged & 32'hFFFF;
        32'h10: m_to     = merged & 32'hFF_FFFF;
        default: ;
      endcase
    end
    m_irq = (m_pend & m_en) != 0;

    @(posedge clk);
    cyc++;
    #1;
    check_eq("irq_o", {31'b0, irq}, {31'b0, m_irq});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(rx, tx, 0, 0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    tick(rx, tx, 1, 1, a, d, 4'hF);
  endtask

  task automatic rd(input logic [31:0] a);
    tick(rx, tx, 1, 0, a, 32'h0, 4'h0);
  endtask

  task automatic pulse(input bit r, input bit t);
    tick(r, t, 0, 0, 32'h0, 32'h0, 4'h0);
    tick(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_irq", {31'b0, irq}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] addrs [10];
    logic [31:0] a, d;
    logic [3:0]  s;
    bit          v, w;
    addrs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h02, 32'h40};

    rx = 0; tx = 0; req = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_irq", {31'b0, irq}, 32'h0);
    rst_n = 1'b1;

    // Reset values
    for (int i = 0; i < 7; i++) rd(addrs[i]);
    rd(32'h08);
    check_eq("rst_rx_thresh", last_rdata, 32'h1);

    // Threshold 1
    wr(32'h00, 32'h3);
    pulse(1, 0);
    check_eq("t1_irq", {31'b0, irq}, 32'h1);
    rd(32'h04);
    check_eq("t1_pending", last_rdata, 32'h1);
    wr(32'h04, 32'h1);
    check_eq("t1_irq_clr", {31'b0, irq}, 32'h0);

    // Threshold 4, timer disabled
    wr(32'h08, 32'h4);
    wr(32'h10, 32'h0);
    for (int i = 0; i < 3; i++) begin
      pulse(1, 0);
      idle(4);
    end
    rd(32'h14);
    check_eq("t2_rx_cnt3", last_rdata, 32'h3);
    check_eq("t2_no_irq", {31'b0, irq}, 32'h0);
    pulse(1, 0);
    rd(32'h04);
    check_eq("t2_pending", last_rdata, 32'h1);
    rd(32'h14);
    check_eq("t2_rx_cnt0", last_rdata, 32'h0);
    wr(32'h04, 32'h3);

    // Timeout on TX
    wr(32'h0C, 32'd100);
    wr(32'h10, 32'd10);
    tick(0, 1, 0, 0, 32'h0, 32'h0, 4'h0);
    tick(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    idle(8);
    rd(32'h04);
    check_eq("t3_not_yet", last_rdata & 32'h2, 32'h0);
    rd(32'h04);
    check_eq("t3_pending", last_rdata & 32'h2, 32'h2);
    rd(32'h18);
    check_eq("t3_tx_cnt0", last_rdata, 32'h0);
    wr(32'h04, 32'h3);

    // Set/clear race on RX
    wr(32'h08, 32'h1);
    wr(32'h10, 32'h0);
    pulse(1, 0);
    tick(1, 0, 1, 1, 32'h04, 32'h1, 4'hF);
    rd(32'h04);
    check_eq("t4_race", last_rdata & 32'h1, 32'h1);
    tick(0, 0, 1, 1, 32'h04, 32'h3, 4'hF);

    // Mask and held level
    wr(32'h00, 32'h0);
    pulse(1, 0);
    check_eq("t5_masked", {31'b0, irq}, 32'h0);
    wr(32'h00, 32'h1);
    check_eq("t5_unmasked", {31'b0, irq}, 32'h1);
    wr(32'h04, 32'h1);
    wr(32'h08, 32'd100);
    rx = 1;
    idle(50);
    rd(32'h14);
    check_eq("t5_held", last_rdata, 32'h1);
    rx = 0;

    // Bus errors, then reset while armed
    rd(32'h1C);
    check_eq("t6_rd_err", {31'b0, last_err}, 32'h1);
    wr(32'h14, 32'h5);
    check_eq("t6_wr_err", {31'b0, last_err}, 32'h1);
    rd(32'h14);
    check_eq("t6_cnt_kept", last_rdata, 32'h1);
    do_reset();
    rd(32'h14);
    check_eq("t6_rst_cnt", last_rdata, 32'h0);
    rd(32'h08);
    check_eq("t6_rst_thr", last_rdata, 32'h1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      v = ($urandom_range(0, 2) == 0);
      w = $urandom_range(0, 1);
      a = addrs[$urandom_range(0, 9)];
      d = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 12);
      s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      tick(($urandom_range(0, 3) == 0) ? ~rx : rx,
           ($urandom_range(0, 3) == 0) ? ~tx : tx,
           v, w, a, d, s);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
